mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  clock; resetn  in  1  synchronous active-low reset.
REQ-002 SHALL have ports: EXE_to_MEM_BUS  in  309  from execute stage; EXE_to_MEM_valid  in  1; MEM_allowin  out  1; WB_allowin  in  1; MEM_to_WB_valid  out  1.
REQ-003 SHALL have ports: data_sram_rdata  in  32  load data, valid exactly one cycle after the execute-stage sram enable.
REQ-004 SHALL have ports: MEM_to_WB_BUS  out  199; MEM_RF_BUS  out  53  forwarding; mem_ex  out  1; mem_ertn  out  1; ertn_flush  in  1; wb_ex  in  1.
REQ-005 EXE_to_MEM_BUS fields, MSB first: pc 32, gr_we 1, dest 5, exe_result 32, mem_sum 32, mem_en 1, load_op 5, rfrom_mem 1, csr_num 14, csr_we 1, csr_wvalue 32, csr_wmask 32, ex 1, ex_code 15, ex_vaddr 32, inst_ertn 1, rfrom_cntid 1, mul_result 64, mul_div_op 7.
REQ-006 load_op bit order SHALL be {ld_b, ld_h, ld_w, ld_bu, ld_hu}; mul_div_op bits 6/5/4 SHALL be mul_w/mulh_w/mulh_wu.
REQ-007 MEM_to_WB_BUS fields, MSB first: pc, gr_we, dest, final_result 32, csr_num, csr_we, csr_wvalue, csr_wmask, ex, ex_code, ex_vaddr, inst_ertn, rfrom_cntid.
REQ-008 MEM_RF_BUS fields, MSB first: fwd_dest 5, final_result 32, MEM_valid 1, csr_we 1, csr_num 14.

Function
REQ-009 MEM_valid register: cleared on ertn_flush or wb_ex; else loaded with EXE_to_MEM_valid when MEM_allowin.
REQ-010 MEM_ready_go SHALL be 1; MEM_allowin = !MEM_valid || WB_allowin; MEM_to_WB_valid = MEM_valid.
REQ-011 Bus register SHALL load EXE_to_MEM_BUS when EXE_to_MEM_valid && MEM_allowin; otherwise hold.
REQ-012 Load-data hold: a flag rdata_held and 32-bit rdata_buf; on first MEM cycle of a valid rfrom_mem instruction with !WB_allowin, capture data_sram_rdata and set rdata_held; clear rdata_held whenever a new instruction is accepted or on flush.
REQ-013 Effective rdata = rdata_held ? rdata_buf : data_sram_rdata.
REQ-014 Byte select by exe_result[1:0]; halfword select by exe_result[1]: ld_b/ld_h sign-extend, ld_bu/ld_hu zero-extend, ld_w whole word.
REQ-015 final_result priority: rfrom_mem -> load result; mul_w -> mul_result[31:0]; mulh_w|mulh_wu -> mul_result[63:32]; else exe_result.
REQ-016 fwd_dest = dest when gr_we && MEM_valid, else 0.
REQ-017 mem_ex = ex && MEM_valid; mem_ertn = inst_ertn && MEM_valid.
REQ-018 Exception fields (ex, ex_code, ex_vaddr) SHALL pass unchanged; an instruction with ex=1 SHALL still present gr_we as received, WB suppresses it.
REQ-019 Simultaneous flush and new EXE valid: flush wins, MEM_valid=0 next cycle.
REQ-020 Back-pressure: while MEM_valid && !WB_allowin all outputs SHALL hold stable across cycles.

Reset
REQ-021 On resetn=0 at clk edge: MEM_valid=0, bus register=0, rdata_held=0, rdata_buf=0.
REQ-022 After reset: MEM_to_WB_valid=0, MEM_allowin=1, mem_ex=0, mem_ertn=0, fwd_dest=0.
REQ-023 Reset mid-stall SHALL drop the held instruction with no output to WB.

Verification
REQ-024 ld_b, exe_result=0x1003, rdata=0x80FF_1234, WB_allowin=1 -> final_result=0xFFFF_FF80 next cycle.
REQ-025 ld_hu, exe_result=0x1002, rdata=0x8001_0000 -> final_result=0x0000_8001; ld_h same -> 0xFFFF_8001.
REQ-026 ld_w accepted, WB_allowin=0 for 3 cycles, rdata changes to 0xDEAD_BEEF after cycle 1 -> final_result keeps first-cycle value until WB_allowin=1.
REQ-027 mulh_wu, mul_result=0x0000_0001_FFFF_FFFE -> final_result=0x0000_0001; mul_w -> 0xFFFF_FFFE.
REQ-028 Valid instruction with ex=1, ex_code=0x9 -> mem_ex=1; assert wb_ex same cycle as new EXE_to_MEM_valid -> MEM_valid=0 next cycle.
REQ-029 gr_we=1, dest=7, MEM_valid=0 -> fwd_dest=0; MEM_valid=1 -> fwd_dest=7.

Source files
------------

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the execute-stage bundle, aligns and
// extends load data, selects the final result and presents the writeback
// and forwarding buses. Load data is latched locally when writeback stalls
// because the SRAM read data is only valid for one cycle.
module mem_stage (
    input  logic         clk,
    input  logic         resetn,
    input  logic [308:0] EXE_to_MEM_BUS,
    input  logic         EXE_to_MEM_valid,
    output logic         MEM_allowin,
    input  logic         WB_allowin,
    output logic         MEM_to_WB_valid,
    input  logic [31:0]  data_sram_rdata,
    output logic [198:0] MEM_to_WB_BUS,
    output logic [52:0]  MEM_RF_BUS,
    output logic         mem_ex,
    output logic         mem_ertn,
    input  logic         ertn_flush,
    input  logic         wb_ex
);

    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] exe_result;
        logic [31:0] mem_sum;
        logic        mem_en;
        logic [4:0]  load_op;      // {ld_b, ld_h, ld_w, ld_bu, ld_hu}
        logic        rfrom_mem;
        logic [13:0] csr_num;
        logic        csr_we;
        logic [31:0] csr_wvalue;
        logic [31:0] csr_wmask;
        logic        ex;
        logic [14:0] ex_code;
        logic [31:0] ex_vaddr;
        logic        inst_ertn;
        logic        rfrom_cntid;
        logic [63:0] mul_result;
        logic [6:0]  mul_div_op;   // [6] mul_w, [5] mulh_w, [4] mulh_wu
    } exe_bus_t;

    exe_bus_t    bus_q, bus_d;
    logic        mem_valid_q, mem_valid_d;
    logic        rdata_held_q, rdata_held_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;

    logic        flush;
    logic        accept;
    logic [31:0] rdata;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_result;
    logic [31:0] final_result;
    logic [4:0]  fwd_dest;
    logic        unused_bits;

    // Handshake: the stage never stalls itself, so it only waits on writeback.
    always_comb begin
        flush           = ertn_flush | wb_ex;
        MEM_allowin     = !mem_valid_q || WB_allowin;
        MEM_to_WB_valid = mem_valid_q;
        accept          = EXE_to_MEM_valid && MEM_allowin;
    end

    // Next-state for valid, bus register and the stalled-load data latch.
    always_comb begin
        mem_valid_d  = mem_valid_q;
        bus_d        = bus_q;
        rdata_held_d = rdata_held_q;
        rdata_buf_d  = rdata_buf_q;
        if (flush) begin
            mem_valid_d = 1'b0;
        end else if (MEM_allowin) begin
            mem_valid_d = EXE_to_MEM_valid;
        end
        if (accept) begin
            bus_d = exe_bus_t'(EXE_to_MEM_BUS);
        end
        // Capture only on the first stalled cycle; later cycles see stale SRAM data.
        if (flush || accept) begin
            rdata_held_d = 1'b0;
        end else if (mem_valid_q && bus_q.rfrom_mem && !WB_allowin && !rdata_held_q) begin
            rdata_held_d = 1'b1;
            rdata_buf_d  = data_sram_rdata;
        end
    end

    // Stage registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid_q  <= 1'b0;
            bus_q        <= '0;
            rdata_held_q <= 1'b0;
            rdata_buf_q  <= '0;
        end else begin
            mem_valid_q  <= mem_valid_d;
            bus_q        <= bus_d;
            rdata_held_q <= rdata_held_d;
            rdata_buf_q  <= rdata_buf_d;
        end
    end

    // Load alignment/extension and final result selection.
    always_comb begin
        rdata = rdata_held_q ? rdata_buf_q : data_sram_rdata;
        case (bus_q.exe_result[1:0])
            2'd0:    load_byte = rdata[7:0];
            2'd1:    load_byte = rdata[15:8];
            2'd2:    load_byte = rdata[23:16];
            default: load_byte = rdata[31:24];
        endcase
        load_half = bus_q.exe_result[1] ? rdata[31:16] : rdata[15:0];
        if (bus_q.load_op[4]) begin
            load_result = {{24{load_byte[7]}}, load_byte};
        end else if (bus_q.load_op[3]) begin
            load_result = {{16{load_half[15]}}, load_half};
        end else if (bus_q.load_op[1]) begin
            load_result = {24'd0, load_byte};
        end else if (bus_q.load_op[0]) begin
            load_result = {16'd0, load_half};
        end else begin
            load_result = rdata;
        end
        if (bus_q.rfrom_mem) begin
            final_result = load_result;
        end else if (bus_q.mul_div_op[6]) begin
            final_result = bus_q.mul_result[31:0];
        end else if (bus_q.mul_div_op[5] || bus_q.mul_div_op[4]) begin
            final_result = bus_q.mul_result[63:32];
        end else begin
            final_result = bus_q.exe_result;
        end
    end

    // Output buses and status flags.
    always_comb begin
        fwd_dest      = (bus_q.gr_we && mem_valid_q) ? bus_q.dest : 5'd0;
        mem_ex        = bus_q.ex && mem_valid_q;
        mem_ertn      = bus_q.inst_ertn && mem_valid_q;
        MEM_to_WB_BUS = {bus_q.pc, bus_q.gr_we, bus_q.dest, final_result,
                         bus_q.csr_num, bus_q.csr_we, bus_q.csr_wvalue, bus_q.csr_wmask,
                         bus_q.ex, bus_q.ex_code, bus_q.ex_vaddr, bus_q.inst_ertn,
                         bus_q.rfrom_cntid};
        MEM_RF_BUS    = {fwd_dest, final_result, mem_valid_q, bus_q.csr_we, bus_q.csr_num};
        unused_bits   = ^{bus_q.mem_sum, bus_q.mem_en, bus_q.mul_div_op[3:0]};
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a scoreboard queue holds expected writeback
// results pushed at issue and popped when the stage hands off to WB.
module tb_mem_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] exe_result;
        logic [31:0] mem_sum;
        logic        mem_en;
        logic [4:0]  load_op;
        logic        rfrom_mem;
        logic [13:0] csr_num;
        logic        csr_we;
        logic [31:0] csr_wvalue;
        logic [31:0] csr_wmask;
        logic        ex;
        logic [14:0] ex_code;
        logic [31:0] ex_vaddr;
        logic        inst_ertn;
        logic        rfrom_cntid;
        logic [63:0] mul_result;
        logic [6:0]  mul_div_op;
    } exe_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [13:0] csr_num;
        logic        csr_we;
        logic [31:0] csr_wvalue;
        logic [31:0] csr_wmask;
        logic        ex;
        logic [14:0] ex_code;
        logic [31:0] ex_vaddr;
        logic        inst_ertn;
        logic        rfrom_cntid;
    } wb_t;

    typedef struct packed {
        logic [4:0]  fwd_dest;
        logic [31:0] final_result;
        logic        valid;
        logic        csr_we;
        logic [13:0] csr_num;
    } rf_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] fr;
    } sb_t;

    localparam logic [4:0] LD_B  = 5'b10000;
    localparam logic [4:0] LD_H  = 5'b01000;
    localparam logic [4:0] LD_W  = 5'b00100;
    localparam logic [4:0] LD_BU = 5'b00010;
    localparam logic [4:0] LD_HU = 5'b00001;

    logic         clk = 1'b0;
    logic         resetn;
    logic [308:0] EXE_to_MEM_BUS;
    logic         EXE_to_MEM_valid;
    logic         MEM_allowin;
    logic         WB_allowin;
    logic         MEM_to_WB_valid;
    logic [31:0]  data_sram_rdata;
    logic [198:0] MEM_to_WB_BUS;
    logic [52:0]  MEM_RF_BUS;
    logic         mem_ex;
    logic         mem_ertn;
    logic         ertn_flush;
    logic         wb_ex;

    wb_t wb;
    rf_t rf;
    sb_t sb_q[$];
    int  checks   = 0;
    int  failures = 0;

    always_comb wb = wb_t'(MEM_to_WB_BUS);
    always_comb rf = rf_t'(MEM_RF_BUS);

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .EXE_to_MEM_BUS  (EXE_to_MEM_BUS),
        .EXE_to_MEM_valid(EXE_to_MEM_valid),
        .MEM_allowin     (MEM_allowin),
        .WB_allowin      (WB_allowin),
        .MEM_to_WB_valid (MEM_to_WB_valid),
        .data_sram_rdata (data_sram_rdata),
        .MEM_to_WB_BUS   (MEM_to_WB_BUS),
        .MEM_RF_BUS      (MEM_RF_BUS),
        .mem_ex          (mem_ex),
        .mem_ertn        (mem_ertn),
        .ertn_flush      (ertn_flush),
        .wb_ex           (wb_ex)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exe_t mk(input logic [31:0] pc, input logic [31:0] exe_result);
        exe_t b;
        b            = '0;
        b.pc         = pc;
        b.gr_we      = 1'b1;
        b.dest       = 5'd3;
        b.exe_result = exe_result;
        return b;
    endfunction

    // Present one instruction for one accepting edge; optionally record its result.
    task automatic send(input exe_t b, input logic [31:0] exp_fr, input logic push);
        sb_t e;
        chk("allowin_at_issue", MEM_allowin, 1'b1);
        EXE_to_MEM_BUS   = b;
        EXE_to_MEM_valid = 1'b1;
        if (push) begin
            e.pc = b.pc;
            e.fr = exp_fr;
            sb_q.push_back(e);
        end
        step();
        EXE_to_MEM_valid = 1'b0;
    endtask

    // Compare the instruction being handed to WB against the scoreboard head.
    task automatic expect_out(input string tag);
        sb_t e;
        chk({tag, "_valid"}, MEM_to_WB_valid, 1'b1);
        if (MEM_to_WB_valid && WB_allowin) begin
            if (sb_q.size() == 0) begin
                chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk({tag, "_pc"}, wb.pc, e.pc);
                chk({tag, "_result"}, wb.final_result, e.fr);
                chk({tag, "_rf_result"}, rf.final_result, e.fr);
            end
        end
    endtask

    initial begin
        exe_t b;
        resetn           = 1'b0;
        EXE_to_MEM_BUS   = '0;
        EXE_to_MEM_valid = 1'b0;
        WB_allowin       = 1'b1;
        data_sram_rdata  = '0;
        ertn_flush       = 1'b0;
        wb_ex            = 1'b0;
        step();
        step();
        resetn = 1'b1;

        chk("rst_valid", MEM_to_WB_valid, 1'b0);
        chk("rst_allowin", MEM_allowin, 1'b1);
        chk("rst_mem_ex", mem_ex, 1'b0);
        chk("rst_mem_ertn", mem_ertn, 1'b0);
        chk("rst_fwd_dest", rf.fwd_dest, 5'd0);
        chk("rst_bus", wb.pc, 32'd0);

        // Sub-word loads
        b = mk(32'h100, 32'h1003); b.rfrom_mem = 1'b1; b.load_op = LD_B;
        send(b, 32'hFFFF_FF80, 1'b1);
        data_sram_rdata = 32'h80FF_1234; #1;
        expect_out("ld_b_3");

        b = mk(32'h104, 32'h1002); b.rfrom_mem = 1'b1; b.load_op = LD_HU;
        send(b, 32'h0000_8001, 1'b1);
        data_sram_rdata = 32'h8001_0000; #1;
        expect_out("ld_hu_2");

        b = mk(32'h108, 32'h1002); b.rfrom_mem = 1'b1; b.load_op = LD_H;
        send(b, 32'hFFFF_8001, 1'b1);
        data_sram_rdata = 32'h8001_0000; #1;
        expect_out("ld_h_2");

        b = mk(32'h10C, 32'h1002); b.rfrom_mem = 1'b1; b.load_op = LD_BU;
        send(b, 32'h0000_00FF, 1'b1);
        data_sram_rdata = 32'h80FF_1234; #1;
        expect_out("ld_bu_2");

        b = mk(32'h110, 32'h1001); b.rfrom_mem = 1'b1; b.load_op = LD_B;
        send(b, 32'h0000_0012, 1'b1);
        data_sram_rdata = 32'h80FF_1234; #1;
        expect_out("ld_b_1");

        b = mk(32'h114, 32'h1000); b.rfrom_mem = 1'b1; b.load_op = LD_H;
        send(b, 32'h0000_1234, 1'b1);
        data_sram_rdata = 32'h80FF_1234; #1;
        expect_out("ld_h_0");

        // Multiply results and priority of load over multiply
        b = mk(32'h118, 32'h5555_5555); b.mul_result = 64'h0000_0001_FFFF_FFFE; b.mul_div_op = 7'b0010000;
        send(b, 32'h0000_0001, 1'b1); #1;
        expect_out("mulh_wu");

        b = mk(32'h11C, 32'h5555_5555); b.mul_result = 64'h0000_0001_FFFF_FFFE; b.mul_div_op = 7'b1000000;
        send(b, 32'hFFFF_FFFE, 1'b1); #1;
        expect_out("mul_w");

        b = mk(32'h120, 32'h5555_5555); b.mul_result = 64'h0000_0001_FFFF_FFFE; b.mul_div_op = 7'b0100000;
        send(b, 32'h0000_0001, 1'b1); #1;
        expect_out("mulh_w");

        b = mk(32'h124, 32'h1000); b.rfrom_mem = 1'b1; b.load_op = LD_W;
        b.mul_result = 64'h0000_0001_FFFF_FFFE; b.mul_div_op = 7'b1000000;
        send(b, 32'hA5A5_0F0F, 1'b1);
        data_sram_rdata = 32'hA5A5_0F0F; #1;
        expect_out("load_over_mul");

        b = mk(32'h128, 32'hCAFE_F00D); b.csr_num = 14'h0123; b.csr_we = 1'b1;
        send(b, 32'hCAFE_F00D, 1'b1); #1;
        chk("rf_csr_num", rf.csr_num, 14'h0123);
        chk("rf_csr_we", rf.csr_we, 1'b1);
        expect_out("alu");

        // Load stalled by writeback: first-cycle data must be held
        b = mk(32'h12C, 32'h2000); b.rfrom_mem = 1'b1; b.load_op = LD_W;
        send(b, 32'h1234_5678, 1'b1);
        WB_allowin      = 1'b0;
        data_sram_rdata = 32'h1234_5678; #1;
        chk("stall_c0_result", wb.final_result, 32'h1234_5678);
        step();
        data_sram_rdata = 32'hDEAD_BEEF; #1;
        for (int i = 0; i < 2; i++) begin
            chk("stall_result", wb.final_result, 32'h1234_5678);
            chk("stall_allowin", MEM_allowin, 1'b0);
            chk("stall_valid", MEM_to_WB_valid, 1'b1);
            step();
        end
        WB_allowin = 1'b1; #1;
        expect_out("stall_release");
        step();
        chk("drain_valid", MEM_to_WB_valid, 1'b0);

        // Forwarding destination gated by valid
        b = mk(32'h130, 32'h1); b.dest = 5'd7;
        send(b, 32'h1, 1'b1); #1;
        chk("fwd_dest_valid", rf.fwd_dest, 5'd7);
        chk("rf_valid", rf.valid, 1'b1);
        expect_out("fwd");
        step();
        chk("fwd_dest_idle", rf.fwd_dest, 5'd0);
        chk("rf_valid_idle", rf.valid, 1'b0);

        // Exception passes through; wb_ex beats a simultaneous new instruction
        b = mk(32'h134, 32'h44); b.ex = 1'b1; b.ex_code = 15'h9; b.ex_vaddr = 32'hBAD0_0001; b.dest = 5'd9;
        send(b, 32'h44, 1'b1); #1;
        chk("mem_ex", mem_ex, 1'b1);
        chk("ex_code", wb.ex_code, 15'h9);
        chk("ex_vaddr", wb.ex_vaddr, 32'hBAD0_0001);
        chk("ex_gr_we", wb.gr_we, 1'b1);
        expect_out("ex_inst");
        EXE_to_MEM_BUS   = mk(32'h138, 32'h55);
        EXE_to_MEM_valid = 1'b1;
        wb_ex            = 1'b1;
        step();
        EXE_to_MEM_valid = 1'b0;
        wb_ex            = 1'b0;
        chk("wb_ex_flush_valid", MEM_to_WB_valid, 1'b0);
        chk("wb_ex_flush_mem_ex", mem_ex, 1'b0);

        // ertn instruction and ertn_flush while stalled
        b = mk(32'h13C, 32'h66); b.inst_ertn = 1'b1;
        send(b, 32'h66, 1'b0);
        WB_allowin = 1'b0; #1;
        chk("mem_ertn", mem_ertn, 1'b1);
        ertn_flush = 1'b1;
        step();
        ertn_flush = 1'b0;
        chk("ertn_flush_valid", MEM_to_WB_valid, 1'b0);
        chk("ertn_flush_mem_ertn", mem_ertn, 1'b0);
        chk("ertn_flush_allowin", MEM_allowin, 1'b1);

        // Reset while stalled drops the instruction
        b = mk(32'h140, 32'h77);
        send(b, 32'h77, 1'b0); #1;
        chk("pre_reset_valid", MEM_to_WB_valid, 1'b1);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("stall_reset_valid", MEM_to_WB_valid, 1'b0);
        chk("stall_reset_allowin", MEM_allowin, 1'b1);
        chk("stall_reset_pc", wb.pc, 32'd0);
        WB_allowin = 1'b1;
        step();
        chk("post_reset_valid", MEM_to_WB_valid, 1'b0);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
